logical_or_acc: RTL

Parametrised, registered logical-OR unit with valid/ready handshake, a sticky OR accumulator and a saturating hit counter. It is the next-generation form of the two-input logical OR gate. Each beat reduces `NUM_IN` one-bit operands to a single logical-OR result, holds it in a one-entry output stage, and tracks whether any accepted beat has evaluated true since the last clear. It sits between a flag-producing source and a status/interrupt consumer.

---
 rtl/logical_or_pkg.sv | 12 +
 rtl/logical_or_sat_cnt.sv | 36 +++
 rtl/logical_or_acc.sv | 85 ++++++++
 3 files changed

// File: rtl/logical_or_pkg.sv
// Shared types and limits for the logical-OR accumulator block.
package logical_or_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } or_state_e;

  localparam int NUM_IN_MIN = 2;
  localparam int NUM_IN_MAX = 32;

endpackage

// File: rtl/logical_or_sat_cnt.sv
// Generic saturating up-counter; clr has priority but a simultaneous inc is
// counted after the clear.
module logical_or_sat_cnt
  import logical_or_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] cnt_p1;

  // stage p1: counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p1 <= '0;
    end else if (clr) begin
      cnt_p1 <= inc ? CNT_W'(1) : '0;
    end else if (inc) begin
      cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign cnt = cnt_p1;

endmodule

// File: rtl/logical_or_acc.sv
// Registered NUM_IN-way logical OR with valid/ready handshake, sticky OR
// accumulator and optional saturating hit counter (LOGICAL_OR_HITCNT_EN).
module logical_or_acc
  import logical_or_pkg::*;
#(
  parameter int NUM_IN = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NUM_IN-1:0] in_data,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out,
  output logic              acc,
  output logic [CNT_W-1:0]  hit_cnt
);

  if (NUM_IN < NUM_IN_MIN || NUM_IN > NUM_IN_MAX) begin : g_bad_num_in
    $error("logical_or_acc: NUM_IN out of range");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("logical_or_acc: CNT_W must be at least 1");
  end

  or_state_e state_q, state_d;
  logic      out_p1;
  logic      acc_p1;
  logic      accept;
  logic      take;
  logic      r_p0;

  assign r_p0      = |in_data;
  assign out_valid = (state_q == FULL);
  assign in_ready  = (state_q == EMPTY) || out_ready;
  assign accept    = in_valid && in_ready;
  assign take      = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (take && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // stage p1: output stage and sticky accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      out_p1  <= 1'b0;
      acc_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) out_p1 <= r_p0;
      if (clear) begin
        acc_p1 <= accept && r_p0;
      end else if (accept) begin
        acc_p1 <= acc_p1 | r_p0;
      end
    end
  end

  assign out = out_p1;
  assign acc = acc_p1;

`ifdef LOGICAL_OR_HITCNT_EN
  logical_or_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept && r_p0),
    .clr   (clear),
    .cnt   (hit_cnt)
  );
`else
  assign hit_cnt = '0;
`endif

endmodule
